countdown_timer_ctrl: RTL and testbench

//  Control side of the mm:ss countdown chain built from the mod-10/mod-6 down counters.

---
 rtl/countdown_timer_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl
// Control FSM for an mm:ss countdown built from a chain of BCD down counters.
// Collects three keypad digits, loads them into the chain, gates its count
// enable from the 1 Hz tick, and reports run state plus a done flag.
// Every output comes straight from a flop; the *_d values are computed from
// the next state so each output lines up with the state it belongs to.

module countdown_timer_ctrl #(
   parameter int TENS_MAX  = 5,
   parameter int DIGIT_MAX = 9
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       tick,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop,
   input  logic       zero_in,
   output logic       cnt_loadn,
   output logic       cnt_clrn,
   output logic       cnt_en,
   output logic [3:0] ld_min,
   output logic [3:0] ld_tens,
   output logic [3:0] ld_ones,
   output logic [2:0] state,
   output logic       done
);

   localparam logic [3:0] TENS_MAX_V  = 4'(TENS_MAX);
   localparam logic [3:0] DIGIT_MAX_V = 4'(DIGIT_MAX);

   typedef enum logic [2:0] {
      ST_ENTRY = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4,
      ST_CLEAR = 3'd5
   } state_t;

   state_t     state_q, state_d;

   // Entry buffer: min <- tens <- ones <- new key
   logic [3:0] buf_min_q,  buf_min_d;
   logic [3:0] buf_tens_q, buf_tens_d;
   logic [3:0] buf_ones_q, buf_ones_d;

   // Registered outputs
   logic [3:0] ld_min_q,  ld_min_d;
   logic [3:0] ld_tens_q, ld_tens_d;
   logic [3:0] ld_ones_q, ld_ones_d;
   logic       cnt_loadn_q, cnt_loadn_d;
   logic       cnt_clrn_q,  cnt_clrn_d;
   logic       cnt_en_q,    cnt_en_d;
   logic       done_q,      done_d;

   logic       buf_nonzero;
   logic       key_legal;
   logic [3:0] tens_clamped;

   assign buf_nonzero  = (buf_min_q != 4'd0) || (buf_tens_q != 4'd0) || (buf_ones_q != 4'd0);
   assign key_legal    = key_valid && (key_digit <= DIGIT_MAX_V);
   assign tens_clamped = (buf_tens_q > TENS_MAX_V) ? TENS_MAX_V : buf_tens_q;

   // Next-state logic; priorities inside RUN are zero_in > stop > tick
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ENTRY: begin
            // an empty buffer would load 0:00 and finish at once, so start is ignored
            if (start && buf_nonzero) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (zero_in) begin
               state_d = ST_DONE;
            end else if (stop) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            // a second stop cancels; it takes precedence over a simultaneous resume
            if (stop) begin
               state_d = ST_CLEAR;
            end else if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (start || stop) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            state_d = ST_ENTRY;
         end
         default: begin
            // unreachable encodings recover through a counter clear
            state_d = ST_CLEAR;
         end
      endcase
   end

   // Entry buffer update: shift on legal keys, zero on stop or on a cancelled pause
   always_comb begin
      buf_min_d  = buf_min_q;
      buf_tens_d = buf_tens_q;
      buf_ones_d = buf_ones_q;
      if (state_q == ST_ENTRY) begin
         if (start && buf_nonzero) begin
            // start wins over a key in the same cycle; the key is dropped
            buf_min_d  = buf_min_q;
         end else if (stop) begin
            buf_min_d  = 4'd0;
            buf_tens_d = 4'd0;
            buf_ones_d = 4'd0;
         end else if (key_legal) begin
            buf_min_d  = buf_tens_q;
            buf_tens_d = buf_ones_q;
            buf_ones_d = key_digit;
         end
      end else if ((state_q == ST_PAUSE) && (state_d == ST_CLEAR)) begin
         // cancelling a paused run forgets the time; finishing a run keeps it
         buf_min_d  = 4'd0;
         buf_tens_d = 4'd0;
         buf_ones_d = 4'd0;
      end
   end

   // Output values for the cycle that follows, derived from the next state
   always_comb begin
      ld_min_d    = ld_min_q;
      ld_tens_d   = ld_tens_q;
      ld_ones_d   = ld_ones_q;
      cnt_loadn_d = (state_d != ST_LOAD);
      cnt_clrn_d  = (state_d != ST_CLEAR);
      done_d      = (state_d == ST_DONE);
      // state_d stays RUN only when neither zero_in nor stop is present
      cnt_en_d    = (state_q == ST_RUN) && (state_d == ST_RUN) && tick;
      if ((state_q == ST_ENTRY) && (state_d == ST_LOAD)) begin
         ld_min_d  = buf_min_q;
         ld_tens_d = tens_clamped;
         ld_ones_d = buf_ones_q;
      end
   end

   // State and buffer registers
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q    <= ST_ENTRY;
         buf_min_q  <= 4'd0;
         buf_tens_q <= 4'd0;
         buf_ones_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         buf_min_q  <= buf_min_d;
         buf_tens_q <= buf_tens_d;
         buf_ones_q <= buf_ones_d;
      end
   end

   // Output registers; reset holds the counter chain in clear
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ld_min_q    <= 4'd0;
         ld_tens_q   <= 4'd0;
         ld_ones_q   <= 4'd0;
         cnt_loadn_q <= 1'b1;
         cnt_clrn_q  <= 1'b0;
         cnt_en_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         ld_min_q    <= ld_min_d;
         ld_tens_q   <= ld_tens_d;
         ld_ones_q   <= ld_ones_d;
         cnt_loadn_q <= cnt_loadn_d;
         cnt_clrn_q  <= cnt_clrn_d;
         cnt_en_q    <= cnt_en_d;
         done_q      <= done_d;
      end
   end

   assign state     = state_q;
   assign ld_min    = ld_min_q;
   assign ld_tens   = ld_tens_q;
   assign ld_ones   = ld_ones_q;
   assign cnt_loadn = cnt_loadn_q;
   assign cnt_clrn  = cnt_clrn_q;
   assign cnt_en    = cnt_en_q;
   assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl
// Directed steps; each step pushes the expected output word to a queue and
// the word is popped and compared one time unit after the next rising edge.

module tb_countdown_timer_ctrl;

   localparam logic [2:0] S_ENTRY = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_CLEAR = 3'd5;

   logic       clk;
   logic       clrn;
   logic       tick;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       start;
   logic       stop;
   logic       zero_in;
   logic       cnt_loadn;
   logic       cnt_clrn;
   logic       cnt_en;
   logic [3:0] ld_min;
   logic [3:0] ld_tens;
   logic [3:0] ld_ones;
   logic [2:0] state;
   logic       done;

   typedef struct {
      string       tag;
      logic [18:0] vec;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp;
   int         n_err;
   logic [3:0] exp_min, exp_tens, exp_ones;

   countdown_timer_ctrl #(.TENS_MAX(5), .DIGIT_MAX(9)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .tick      (tick),
      .key_valid (key_valid),
      .key_digit (key_digit),
      .start     (start),
      .stop      (stop),
      .zero_in   (zero_in),
      .cnt_loadn (cnt_loadn),
      .cnt_clrn  (cnt_clrn),
      .cnt_en    (cnt_en),
      .ld_min    (ld_min),
      .ld_tens   (ld_tens),
      .ld_ones   (ld_ones),
      .state     (state),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output word for a steady (non-reset) state
   function automatic logic [18:0] mk(input logic [2:0] s, input bit en);
      logic loadn_e, clrn_e, done_e;
      loadn_e = (s == S_LOAD)  ? 1'b0 : 1'b1;
      clrn_e  = (s == S_CLEAR) ? 1'b0 : 1'b1;
      done_e  = (s == S_DONE)  ? 1'b1 : 1'b0;
      return {s, loadn_e, clrn_e, en ? 1'b1 : 1'b0, done_e, exp_min, exp_tens, exp_ones};
   endfunction

   function automatic logic [18:0] reset_vec();
      return {S_ENTRY, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
   endfunction

   task automatic push(input string tag, input logic [18:0] v);
      exp_t e;
      e.tag = tag;
      e.vec = v;
      sb.push_back(e);
   endtask

   task automatic check_front();
      exp_t        e;
      logic [18:0] obs;
      obs = {state, cnt_loadn, cnt_clrn, cnt_en, done, ld_min, ld_tens, ld_ones};
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.vec) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", e.tag, obs, e.vec);
         end
         $display("step %-14s obs=%h exp=%h", e.tag, obs, e.vec);
      end
   endtask

   task automatic step(input string tag, input bit t, input bit kv, input logic [3:0] kd,
                       input bit st, input bit sp, input bit z,
                       input logic [2:0] es, input bit een);
      tick      = t;
      key_valid = kv;
      key_digit = kd;
      start     = st;
      stop      = sp;
      zero_in   = z;
      push(tag, mk(es, een));
      @(posedge clk);
      #1;
      tick      = 1'b0;
      key_valid = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      check_front();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      exp_min = 4'd0; exp_tens = 4'd0; exp_ones = 4'd0;
      clrn = 1'b1; tick = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
      start = 1'b0; stop = 1'b0; zero_in = 1'b0;

      // reset state
      #2 clrn = 1'b0;
      #1;
      push("reset", reset_vec());
      check_front();
      @(posedge clk);
      #1 clrn = 1'b1;

      // keys 1,2,5 then start -> LOAD with 1,2,5, then RUN
      step("key1",      0, 1, 4'd1, 0, 0, 0, S_ENTRY, 0);
      step("key2",      0, 1, 4'd2, 0, 0, 0, S_ENTRY, 0);
      step("key5",      0, 1, 4'd5, 0, 0, 0, S_ENTRY, 0);
      exp_min = 4'd1; exp_tens = 4'd2; exp_ones = 4'd5;
      step("load125",   0, 0, 4'd0, 1, 0, 0, S_LOAD,  0);
      step("run_enter", 0, 0, 4'd0, 0, 0, 0, S_RUN,   0);
      step("run_tick",  1, 0, 4'd0, 0, 0, 0, S_RUN,   1);
      step("run_idle",  0, 0, 4'd0, 0, 0, 0, S_RUN,   0);

      // zero_in and tick together -> DONE with no enable
      step("zero_tick", 1, 0, 4'd0, 0, 0, 1, S_DONE,  0);
      step("done_hold", 0, 0, 4'd0, 0, 0, 1, S_DONE,  0);
      step("done_start",0, 0, 4'd0, 1, 0, 0, S_CLEAR, 0);
      step("clr_entry", 0, 0, 4'd0, 0, 0, 0, S_ENTRY, 0);
      // buffer retained after DONE: start reloads the same time
      step("reload",    0, 0, 4'd0, 1, 0, 0, S_LOAD,  0);
      step("rerun",     0, 0, 4'd0, 0, 0, 0, S_RUN,   0);

      // pause ignores ticks, resume, then cancel
      step("stop_pause",0, 0, 4'd0, 0, 1, 0, S_PAUSE, 0);
      for (int i = 0; i < 5; i++) begin
         step("pause_tick", 1, 0, 4'd0, 0, 0, 0, S_PAUSE, 0);
      end
      step("resume",    0, 0, 4'd0, 1, 0, 0, S_RUN,   0);
      step("resume_tk", 1, 0, 4'd0, 0, 0, 0, S_RUN,   1);
      step("pause2",    0, 0, 4'd0, 0, 1, 0, S_PAUSE, 0);
      step("cancel",    0, 0, 4'd0, 0, 1, 0, S_CLEAR, 0);
      step("cancel_ent",0, 0, 4'd0, 0, 0, 0, S_ENTRY, 0);
      // buffer was zeroed, so start is ignored
      step("empty_start",0,0, 4'd0, 1, 0, 0, S_ENTRY, 0);

      // keys 0,9,4 -> tens clamped; keys A..F ignored
      step("key0",      0, 1, 4'd0, 0, 0, 0, S_ENTRY, 0);
      step("key9",      0, 1, 4'd9, 0, 0, 0, S_ENTRY, 0);
      step("key4",      0, 1, 4'd4, 0, 0, 0, S_ENTRY, 0);
      for (int k = 10; k < 16; k++) begin
         step("bad_key", 0, 1, 4'(k), 0, 0, 0, S_ENTRY, 0);
      end
      exp_min = 4'd0; exp_tens = 4'd5; exp_ones = 4'd4;
      step("load_clamp",0, 0, 4'd0, 1, 0, 0, S_LOAD,  0);
      step("run2",      0, 0, 4'd0, 0, 0, 0, S_RUN,   0);
      step("pause3",    0, 0, 4'd0, 0, 1, 0, S_PAUSE, 0);
      step("cancel2",   0, 0, 4'd0, 0, 1, 0, S_CLEAR, 0);
      step("entry3",    0, 0, 4'd0, 0, 0, 0, S_ENTRY, 0);

      // start and key in the same cycle: load wins, key dropped
      step("key3",      0, 1, 4'd3, 0, 0, 0, S_ENTRY, 0);
      exp_min = 4'd0; exp_tens = 4'd0; exp_ones = 4'd3;
      step("start_key7",0, 1, 4'd7, 1, 0, 0, S_LOAD,  0);
      step("run3",      0, 0, 4'd0, 0, 0, 0, S_RUN,   0);
      step("run3_tick", 1, 0, 4'd0, 0, 0, 0, S_RUN,   1);

      // asynchronous reset mid-RUN, checked before any clock edge
      #2 clrn = 1'b0;
      #1;
      exp_min = 4'd0; exp_tens = 4'd0; exp_ones = 4'd0;
      push("async_reset", reset_vec());
      check_front();
      @(posedge clk);
      #1 clrn = 1'b1;

      // stop in ENTRY zeroes the buffer
      step("key8",      0, 1, 4'd8, 0, 0, 0, S_ENTRY, 0);
      step("entry_stop",0, 0, 4'd0, 0, 1, 0, S_ENTRY, 0);
      step("start_zero",0, 0, 4'd0, 1, 0, 0, S_ENTRY, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
